// File: rtl/result_writer.sv
// Write-back engine: snapshots a ROWS x COLS result block, streams it row-major.
// Optional RESULT_WRITER_RELU_EN clamps negative words to zero at snapshot time.
module result_writer #(
    parameter int DW        = 16,
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int AW        = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] DATA_IN [0:ROWS-1][0:COLS-1],
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ready,
    output logic          busy,
    output logic          done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] r, r_n;
    logic [CW-1:0] c, c_n;
    logic [DW-1:0] snap [0:ROWS-1][0:COLS-1];
    logic          load;
    logic          wr_en_n, busy_n, done_n;
    logic [AW-1:0] wr_addr_n;
    logic [DW-1:0] wr_data_n;
    logic          last;

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] w);
`ifdef RESULT_WRITER_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    assign last = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

    always_comb begin
        state_n   = state;
        r_n       = r;
        c_n       = c;
        load      = 1'b0;
        wr_en_n   = wr_en;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_n   = WRITE;
                    r_n       = '0;
                    c_n       = '0;
                    wr_en_n   = 1'b1;
                    wr_addr_n = AW'(BASE_ADDR);
                    wr_data_n = clamp(DATA_IN[0][0]);
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (last) begin
                        state_n = DONE;
                        wr_en_n = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        // next element becomes visible the cycle after acceptance
                        if (c == CW'(COLS - 1)) begin
                            c_n = '0;
                            r_n = r + 1'b1;
                        end else begin
                            c_n = c + 1'b1;
                        end
                        wr_addr_n = wr_addr + 1'b1;
                        wr_data_n = snap[r_n][c_n];
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                wr_en_n = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r       <= '0;
            c       <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    snap[i][j] <= '0;
        end else begin
            state   <= state_n;
            r       <= r_n;
            c       <= c_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
            if (load) begin
                for (int i = 0; i < ROWS; i++)
                    for (int j = 0; j < COLS; j++)
                        snap[i][j] <= clamp(DATA_IN[i][j]);
            end
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: two instances (BASE_ADDR 0 and 50) against a
// block-level model of the stream, plus literal timing/data pins.
module tb_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr_ready = 1'b0;
    logic [15:0] din [0:4][0:4];

    logic        en0, en1, bz0, bz1, dn0, dn1;
    logic [5:0]  a0, a1;
    logic [15:0] d0, d1;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    result_writer #(.BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .DATA_IN(din),
        .wr_en(en0), .wr_addr(a0), .wr_data(d0), .wr_ready(wr_ready),
        .busy(bz0), .done(dn0)
    );

    result_writer #(.BASE_ADDR(50)) u1 (
        .clk(clk), .rst(rst), .start(start), .DATA_IN(din),
        .wr_en(en1), .wr_addr(a1), .wr_data(d1), .wr_ready(wr_ready),
        .busy(bz1), .done(dn1)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [15:0] relu(logic [15:0] w);
`ifdef RESULT_WRITER_RELU_EN
        return (w >= 16'h8000) ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    // Model: block of 25 words, a position in it, and a one-cycle done phase.
    bit          m_act = 0;
    bit          m_done = 0;
    int          m_idx = 0;
    logic [15:0] m_snap [25];

    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_done = 0; m_idx = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_act) begin
            if (wr_ready) begin
                m_idx++;
                if (m_idx == 25) begin
                    m_act = 0; m_done = 1;
                end
            end
        end else if (start) begin
            for (int i = 0; i < 25; i++) m_snap[i] = relu(din[i / 5][i % 5]);
            m_act = 1; m_idx = 0;
        end
    end

    bit          p_stall = 0;
    logic [5:0]  p_a;
    logic [15:0] p_d;

    always @(negedge clk) begin
        check("wr_en0", en0, m_act);
        check("wr_en1", en1, m_act);
        check("busy0", bz0, m_act || m_done);
        check("busy1", bz1, m_act || m_done);
        check("done0", dn0, m_done);
        check("done1", dn1, m_done);
        if (m_act) begin
            check("addr0", a0, m_idx % 64);
            check("addr1", a1, (50 + m_idx) % 64);
            check("data0", d0, m_snap[m_idx]);
            check("data1", d1, m_snap[m_idx]);
        end
        if (p_stall) check("stall_hold", {a0, d0}, {p_a, p_d});
        p_stall = en0 && !wr_ready && !rst;
        p_a = a0;
        p_d = d0;
        if (dn0) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(int cap);
        int k = 0;
        while ((m_act || m_done) && k < cap) begin
            tick();
            k++;
        end
        tick();
        check("idle_reached", bz0, 1'b0);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                din[r][c] = 16'h0100 + 16'(r * 5 + c);
    endtask

    initial begin
        fill_pattern();
        tick();
        tick();
        check("rst_wr_en", en0, 1'b0);
        check("rst_addr", a0, 6'd0);
        check("rst_data", d0, 16'h0000);
        check("rst_busy", bz0, 1'b0);
        check("rst_done", dn0, 1'b0);
        rst = 1'b0;
        tick();

        // Back-to-back burst with literal timing pins
        wr_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("b1_first_data", d0, 16'h0100);
        check("b1_first_addr1", a1, 6'd50);
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 13) check("b1_addr1_63", a1, 6'd63);
            if (k == 14) check("b1_addr1_wrap", a1, 6'd0);
        end
        @(negedge clk);
        check("b1_last_data", d0, 16'h0118);
        check("b1_last_addr0", a0, 6'd24);
        check("b1_last_addr1", a1, 6'd10);
        check("b1_last_en", en0, 1'b1);
        tick();
        check("b1_done_e25", dn0, 1'b1);
        check("b1_en_off_e25", en0, 1'b0);
        check("b1_busy_e25", bz0, 1'b1);
        tick();
        check("b1_done_e26", dn0, 1'b0);
        check("b1_busy_e26", bz0, 1'b0);

        // Alternating ready
        wr_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 120 && (m_act || m_done); k++) begin
            wr_ready = ~wr_ready;
            tick();
        end
        wr_ready = 1'b1;
        wait_idle(10);

        // Ignored second start and post-start data change
        n_done = 0;
        pulse_start();
        for (int k = 0; k < 6; k++) tick();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                din[r][c] = 16'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(60);
        check("single_done", n_done, 1);

        // Reset after beat 12
        fill_pattern();
        pulse_start();
        for (int k = 0; k < 12; k++) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("mid_rst_en", en0, 1'b0);
        check("mid_rst_busy", bz0, 1'b0);
        check("mid_rst_done", dn0, 1'b0);
        tick();
        pulse_start();
        @(negedge clk);
        check("restart_addr", a0, 6'd0);
        check("restart_data", d0, 16'h0100);
        wait_idle(60);

        // Sign handling of the first two words
        din[0][0] = 16'hFFF6;
        din[0][1] = 16'h000A;
        pulse_start();
        @(negedge clk);
`ifdef RESULT_WRITER_RELU_EN
        check("neg_word", d0, 16'h0000);
`else
        check("neg_word", d0, 16'hFFF6);
`endif
        tick();
        check("pos_word", d0, 16'h000A);
        wait_idle(60);

        // Randomized traffic
        for (int b = 0; b < 20; b++) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    din[r][c] = 16'($urandom);
            for (int k = 0; k < 70; k++) begin
                wr_ready = ($urandom_range(3) != 0);
                start = ($urandom_range(5) == 0);
                rst = ($urandom_range(150) == 0);
                if ($urandom_range(7) == 0) din[$urandom_range(4)][$urandom_range(4)] = 16'($urandom);
                tick();
            end
            start = 1'b0;
            rst = 1'b0;
            wr_ready = 1'b1;
            wait_idle(60);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
